// File: rtl/simple_uart_pkg.sv
// Timing and width definitions shared by both ends of the simple_uart family,
// so that transmitter and receiver always agree on bit timing.
package simple_uart_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 8;

  // Number of system clock cycles spanned by one bit on the line.
  function automatic int unsigned bit_cycles(input int unsigned clock_frequency,
                                             input int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/simple_synchronizer.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen by the instantiating block to match the input's idle level.
module simple_synchronizer #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      dout <= RESET_VALUE;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/simple_receiver.sv
// UART receiver: samples an 8N1-style line at mid-bit, writes each well-framed
// word into a downstream FIFO and flags framing errors and overruns.
module simple_receiver
  import simple_uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd115200,
  parameter int unsigned WORD_WIDTH      = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  full,
  output logic                  we,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int unsigned ONE_CYCLE  = bit_cycles(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF_CYCLE = ONE_CYCLE / 2;
  localparam logic [31:0] ONE_LAST   = 32'(ONE_CYCLE - 1);
  localparam logic [31:0] HALF_LAST  = 32'(HALF_CYCLE - 1);
  localparam logic [31:0] WORD_LAST  = 32'(WORD_WIDTH - 1);

  generate
    if (ONE_CYCLE < 4) begin : g_timing_check
      $error("simple_receiver: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  rx_state_t             state;
  rx_state_t             next_state;
  logic                  rx_s;
  logic [31:0]           clocks;
  logic [31:0]           received_bits;
  logic [WORD_WIDTH-1:0] shift;
  logic                  bit_done;
  logic                  half_done;
  logic                  last_bit;
  logic                  we_d;
  logic                  frame_error_d;
  logic                  overrun_d;

  simple_synchronizer #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(rx_s)
  );

  assign bit_done  = (clocks == ONE_LAST);
  assign half_done = (clocks == HALF_LAST);
  assign last_bit  = (received_bits == WORD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (half_done) next_state = rx_s ? IDLE : DATA;
      DATA:    if (bit_done && last_bit) next_state = STOP;
      STOP:    if (bit_done) next_state = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Leaving STOP right at mid-stop-bit lets a back-to-back start edge be seen.
  always_comb begin
    we_d          = 1'b0;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    if (state == STOP && bit_done) begin
      we_d          = rx_s && !full;
      overrun_d     = rx_s && full;
      frame_error_d = !rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clocks        <= '0;
      received_bits <= '0;
      shift         <= '0;
    end else begin
      case (state)
        START: clocks <= half_done ? '0 : clocks + 32'd1;
        DATA: begin
          if (bit_done) begin
            shift         <= {rx_s, shift[WORD_WIDTH-1:1]};
            received_bits <= received_bits + 32'd1;
            clocks        <= '0;
          end else begin
            clocks <= clocks + 32'd1;
          end
        end
        STOP: clocks <= bit_done ? '0 : clocks + 32'd1;
        default: begin
          clocks        <= '0;
          received_bits <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we          <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      dout        <= '0;
    end else begin
      we          <= we_d;
      frame_error <= frame_error_d;
      overrun     <= overrun_d;
      if (we_d) dout <= shift;
    end
  end

endmodule

// File: tb/tb_simple_receiver.sv
// Bench for simple_receiver at 10 clocks per bit: a table of frames plus
// hand-written glitch, break and mid-frame reset sequences, with a pulse scoreboard.
module tb_simple_receiver;

  localparam int unsigned BITC = 10;
  // Clocks from the start-bit drive to the output pulse being visible:
  // 2 synchroniser + 1 detect + 5 half bit + 8 data bits + 1 stop-bit wait.
  localparam int unsigned LAT  = 98;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b1;
  logic       full = 1'b0;
  logic       we;
  logic       frame_error;
  logic       overrun;
  logic [7:0] dout;

  simple_receiver #(
    .CLOCK_FREQUENCY(32'd1_000_000),
    .BAUD_RATE      (32'd100_000),
    .WORD_WIDTH     (32'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .full       (full),
    .we         (we),
    .dout       (dout),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_WE, EV_FE, EV_OV} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    ev_kind_t   kind;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_dout;
  logic       done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_we"}, {31'b0, we}, 32'd0);
    check({name, "_frame_error"}, {31'b0, frame_error}, 32'd0);
    check({name, "_overrun"}, {31'b0, overrun}, 32'd0);
    check({name, "_dout"}, {24'b0, dout}, 32'd0);
  endtask

  // Caller is 1 time unit after a rising edge; each bit lasts BITC clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic f,
                            input ev_kind_t k);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    full = f;
    sb.push_back('{kind: k, data: d, at: cyc + LAT});
    for (int i = 0; i < 10; i++) begin
      din = bits[i];
      repeat (BITC) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, full: 1'b0, kind: EV_WE};
    vecs[1] = '{data: 8'h11, stop: 1'b1, full: 1'b0, kind: EV_WE};
    vecs[2] = '{data: 8'h7E, stop: 1'b1, full: 1'b1, kind: EV_OV};
    vecs[3] = '{data: 8'h00, stop: 1'b1, full: 1'b0, kind: EV_WE};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, full: 1'b0, kind: EV_WE};
    vecs[5] = '{data: 8'h3C, stop: 1'b1, full: 1'b0, kind: EV_WE};

    fork
      begin : monitor
        exp_t     e;
        ev_kind_t seen;
        while (!done) begin
          @(negedge clk);
          if (rst && (we || frame_error || overrun)) begin
            check("pulse_exclusive", 32'(int'(we) + int'(frame_error) + int'(overrun)), 32'd1);
            seen = we ? EV_WE : (frame_error ? EV_FE : EV_OV);
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)",
                       seen, cyc);
            end else begin
              e = sb.pop_front();
              check("pulse_kind", 32'(seen), 32'(e.kind));
              check("pulse_cycle", cyc, e.at);
              if (e.kind == EV_WE) check("pulse_dout", {24'b0, dout}, {24'b0, e.data});
            end
          end
        end
      end

      begin : stimulus
        idle_cycles(3);
        check_idle_outputs("reset");
        rst = 1'b1;
        idle_cycles(5);

        // Table frames are sent with no idle gap between them.
        model_dout = 8'h00;
        for (int i = 0; i < 6; i++) begin
          send_frame(vecs[i].data, vecs[i].stop, vecs[i].full, vecs[i].kind);
          if (!vecs[i].full) model_dout = vecs[i].data;
          check("dout_hold", {24'b0, dout}, {24'b0, model_dout});
        end
        full = 1'b0;
        idle_cycles(20);

        din = 1'b0;
        idle_cycles(3);
        din = 1'b1;
        idle_cycles(20);
        check("glitch_sb_empty", sb.size(), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, EV_WE);
        check("after_glitch_dout", {24'b0, dout}, 32'h3C);

        // Stop bit low, line held low afterwards: one framing error only.
        idle_cycles(10);
        send_frame(8'h55, 1'b0, 1'b0, EV_FE);
        idle_cycles(30);
        check("break_sb_empty", sb.size(), 32'd0);
        din = 1'b1;
        idle_cycles(10);
        send_frame(8'h3C, 1'b1, 1'b0, EV_WE);
        check("after_break_dout", {24'b0, dout}, 32'h3C);

        // 0xC3 LSB first is 1,1,0,0,0,0,1,1; reset lands inside data bit 4.
        idle_cycles(10);
        begin
          logic [7:0] c3;
          c3 = 8'hC3;
          din = 1'b0;
          idle_cycles(BITC);
          for (int b = 0; b < 4; b++) begin
            din = c3[b];
            idle_cycles(BITC);
          end
          din = c3[4];
          idle_cycles(4);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_idle_outputs("mid_frame_reset");
        end
        #1;
        din = 1'b1;
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(BITC * 12);
        check("reset_abort_sb_empty", sb.size(), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, EV_WE);
        check("after_reset_dout", {24'b0, dout}, 32'h81);

        idle_cycles(20);
        check("final_sb_empty", sb.size(), 32'd0);
        done = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
